// File: rtl/ddr_to_rgb.sv
// rtl/ddr_to_rgb.sv - streams a DDR frame buffer from MIG port 1 into the output pixel FIFO
//
// Purpose: after MIG calibration, repeatedly reads one frame of PIXEL_COUNT
// 32-bit words (64-word bursts from byte address 0 upward) and writes the low
// RGB_WIDTH bits of each word into the output pixel FIFO, forever.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   c3_calib_done            MIG calibration complete
//   c3_p1_cmd_*              MIG port-1 command channel (read bursts)
//   c3_p1_rd_*               MIG port-1 read-data channel
//   fifo_data_in/_write_enable, fifo_wr_data_count, fifo_full
//                            output pixel FIFO write side
//   led                      [0] calib, [1] frame toggle, [6:2] frame count, [7] sticky error
module ddr_to_rgb #(
  parameter int RGB_WIDTH        = 24,
  parameter int DATA_COUNT_WIDTH = 11,
  parameter int PIXEL_COUNT      = 4096,
  parameter int FIFO_DEPTH       = 2048
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        c3_calib_done,
  output logic                        c3_p1_cmd_en,
  output logic [2:0]                  c3_p1_cmd_instr,
  output logic [5:0]                  c3_p1_cmd_bl,
  output logic [29:0]                 c3_p1_cmd_byte_addr,
  input  logic                        c3_p1_cmd_empty,
  input  logic                        c3_p1_cmd_full,
  output logic                        c3_p1_rd_en,
  input  logic [31:0]                 c3_p1_rd_data,
  input  logic                        c3_p1_rd_full,
  input  logic                        c3_p1_rd_empty,
  input  logic [6:0]                  c3_p1_rd_count,
  input  logic                        c3_p1_rd_overflow,
  input  logic                        c3_p1_rd_error,
  output logic [RGB_WIDTH-1:0]        fifo_data_in,
  output logic                        fifo_write_enable,
  input  logic [DATA_COUNT_WIDTH-1:0] fifo_wr_data_count,
  input  logic                        fifo_full,
  output logic [7:0]                  led
);

  localparam logic [2:0] WAIT_CALIB   = 3'd0;
  localparam logic [2:0] WAIT_SPACE   = 3'd1;
  localparam logic [2:0] READ_COMMAND = 3'd2;
  localparam logic [2:0] READ_DATA    = 3'd3;
  localparam logic [2:0] FRAME_DONE   = 3'd4;

  localparam int BURSTS      = PIXEL_COUNT / 64;
  localparam int BW          = $clog2(BURSTS + 1);
  localparam int SPACE_LIMIT = FIFO_DEPTH - 64;

  logic [2:0]    state;
  logic [29:0]   addr_ptr;
  logic [6:0]    word_count;
  logic [BW-1:0] burst_count;
  logic [BW-1:0] burst_next;
  logic [7:0]    frame_count;
  logic          error_flag;
  logic          frame_toggle;
  logic          calib_q;
  logic          space_ok;

  // These MIG status inputs carry no information the sequencer needs.
  logic unused_inputs;
  assign unused_inputs = ^{c3_p1_cmd_empty, c3_p1_rd_full, c3_p1_rd_count, c3_p1_rd_data};

  // Only request a burst when the whole 64-pixel burst is guaranteed to fit.
  assign space_ok = (64'(fifo_wr_data_count) <= 64'(SPACE_LIMIT)) && !fifo_full;

  // Gated by rst so a mid-burst reset stops popping within the reset cycle itself.
  assign c3_p1_rd_en = !rst && (state == READ_DATA) && !c3_p1_rd_empty && !fifo_full;

  assign burst_next = burst_count + BW'(1);

  assign led = {error_flag, frame_count[4:0], frame_toggle, calib_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= WAIT_CALIB;
      c3_p1_cmd_en        <= 1'b0;
      c3_p1_cmd_instr     <= 3'b000;
      c3_p1_cmd_bl        <= 6'd0;
      c3_p1_cmd_byte_addr <= 30'd0;
      fifo_write_enable   <= 1'b0;
      fifo_data_in        <= '0;
      addr_ptr            <= 30'd0;
      word_count          <= 7'd0;
      burst_count         <= '0;
      frame_count         <= 8'd0;
      error_flag          <= 1'b0;
      frame_toggle        <= 1'b0;
      calib_q             <= 1'b0;
    end else begin
      c3_p1_cmd_en      <= 1'b0;
      calib_q           <= c3_calib_done;
      fifo_write_enable <= c3_p1_rd_en;
      if (c3_p1_rd_en) begin
        fifo_data_in <= c3_p1_rd_data[RGB_WIDTH-1:0];
      end
      // Read-side faults are only meaningful once the MIG is calibrated.
      if ((state != WAIT_CALIB) && (c3_p1_rd_overflow || c3_p1_rd_error)) begin
        error_flag <= 1'b1;
      end

      case (state)
        WAIT_CALIB: begin
          if (c3_calib_done) state <= WAIT_SPACE;
        end
        WAIT_SPACE: begin
          if (space_ok) state <= READ_COMMAND;
        end
        READ_COMMAND: begin
          if (!c3_p1_cmd_full) begin
            c3_p1_cmd_en        <= 1'b1;
            c3_p1_cmd_instr     <= 3'b011;
            c3_p1_cmd_bl        <= 6'd63;
            c3_p1_cmd_byte_addr <= addr_ptr;
            addr_ptr            <= addr_ptr + 30'd256;
            state               <= READ_DATA;
          end
        end
        READ_DATA: begin
          if (c3_p1_rd_en) begin
            if (word_count == 7'd63) begin
              word_count  <= 7'd0;
              burst_count <= burst_next;
              state       <= (burst_next == BW'(BURSTS)) ? FRAME_DONE : WAIT_SPACE;
            end else begin
              word_count <= word_count + 7'd1;
            end
          end
        end
        FRAME_DONE: begin
          addr_ptr     <= 30'd0;
          burst_count  <= '0;
          frame_count  <= frame_count + 8'd1;
          frame_toggle <= ~frame_toggle;
          state        <= WAIT_SPACE;
        end
        default: state <= WAIT_CALIB;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_to_rgb.sv
// tb/tb_ddr_to_rgb.sv - scoreboard bench for ddr_to_rgb with a MIG read-port model
module tb_ddr_to_rgb;

  localparam int PIX   = 256;
  localparam int BURST = PIX / 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c3_calib_done = 1'b0;
  logic        c3_p1_cmd_en;
  logic [2:0]  c3_p1_cmd_instr;
  logic [5:0]  c3_p1_cmd_bl;
  logic [29:0] c3_p1_cmd_byte_addr;
  logic        c3_p1_cmd_empty = 1'b1;
  logic        c3_p1_cmd_full = 1'b0;
  logic        c3_p1_rd_en;
  logic [31:0] c3_p1_rd_data = 32'd0;
  logic        c3_p1_rd_full = 1'b0;
  logic        c3_p1_rd_empty = 1'b1;
  logic [6:0]  c3_p1_rd_count = 7'd0;
  logic        c3_p1_rd_overflow = 1'b0;
  logic        c3_p1_rd_error = 1'b0;
  logic [23:0] fifo_data_in;
  logic        fifo_write_enable;
  logic [10:0] fifo_wr_data_count = 11'd0;
  logic        fifo_full = 1'b0;
  logic [7:0]  led;

  always #5 clk = ~clk;

  ddr_to_rgb #(.RGB_WIDTH(24), .DATA_COUNT_WIDTH(11), .PIXEL_COUNT(PIX), .FIFO_DEPTH(2048)) dut (
    .clk(clk), .rst(rst), .c3_calib_done(c3_calib_done),
    .c3_p1_cmd_en(c3_p1_cmd_en), .c3_p1_cmd_instr(c3_p1_cmd_instr), .c3_p1_cmd_bl(c3_p1_cmd_bl),
    .c3_p1_cmd_byte_addr(c3_p1_cmd_byte_addr), .c3_p1_cmd_empty(c3_p1_cmd_empty),
    .c3_p1_cmd_full(c3_p1_cmd_full), .c3_p1_rd_en(c3_p1_rd_en), .c3_p1_rd_data(c3_p1_rd_data),
    .c3_p1_rd_full(c3_p1_rd_full), .c3_p1_rd_empty(c3_p1_rd_empty), .c3_p1_rd_count(c3_p1_rd_count),
    .c3_p1_rd_overflow(c3_p1_rd_overflow), .c3_p1_rd_error(c3_p1_rd_error),
    .fifo_data_in(fifo_data_in), .fifo_write_enable(fifo_write_enable),
    .fifo_wr_data_count(fifo_wr_data_count), .fifo_full(fifo_full), .led(led)
  );

  int checks = 0;
  int errors = 0;
  int pix_rx = 0;
  int bursts = 0;
  bit err_model = 1'b0;
  bit rand_en = 1'b0;

  logic [23:0] exp_pix_q[$];
  logic [29:0] exp_cmd_q[$];
  logic [31:0] mig_q[$];

  // DDR contents: word at byte address a; low 24 bits = 0xAABB00 + word index.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'h5A000000 | (32'h00AABB00 + 32'(a >> 2));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // MIG read-port model: serves 64 words per read command, with random gaps and back-pressure.
  initial begin : mig_model
    bit pop, cmd, gap;
    logic [29:0] caddr;
    forever begin
      @(negedge clk);
      pop = c3_p1_rd_en;
      cmd = c3_p1_cmd_en;
      caddr = c3_p1_cmd_byte_addr;
      @(posedge clk);
      #1;
      if (pop && mig_q.size() > 0) void'(mig_q.pop_front());
      if (cmd) for (int i = 0; i < 64; i++) mig_q.push_back(mem_word(caddr + 30'(4 * i)));
      gap = rand_en && ($urandom % 4 == 0);
      c3_p1_rd_empty = (mig_q.size() == 0) || gap;
      c3_p1_rd_data = (mig_q.size() > 0) ? mig_q[0] : $urandom;
      fifo_full = rand_en && ($urandom % 3 == 0);
      c3_p1_cmd_full = rand_en && ($urandom % 4 == 0);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a command or a pixel.
  bit prev_rd_en = 1'b0;
  bit prev_cmd_en = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_rd_en = 1'b0;
      prev_cmd_en = 1'b0;
    end else begin
      if (c3_p1_rd_en) begin
        check("rd_en_while_fifo_full", 64'(fifo_full), 64'd0);
        check("rd_en_while_rd_empty", 64'(c3_p1_rd_empty), 64'd0);
      end
      if (fifo_write_enable || prev_rd_en)
        check("write_latency", 64'(fifo_write_enable), 64'(prev_rd_en));
      if (fifo_write_enable) begin
        pix_rx++;
        if (exp_pix_q.size() == 0) check("unexpected_pixel", 64'(fifo_data_in), 64'hFFFFFFFFFF);
        else check("pixel_data", 64'(fifo_data_in), 64'(exp_pix_q.pop_front()));
      end
      if (c3_p1_cmd_en) begin
        check("cmd_single_pulse", 64'(prev_cmd_en), 64'd0);
        check("cmd_instr", 64'(c3_p1_cmd_instr), 64'd3);
        check("cmd_bl", 64'(c3_p1_cmd_bl), 64'd63);
        if (exp_cmd_q.size() == 0) check("unexpected_cmd", 64'(c3_p1_cmd_byte_addr), 64'hFFFFFFFFFF);
        else check("cmd_addr", 64'(c3_p1_cmd_byte_addr), 64'(exp_cmd_q.pop_front()));
      end
      prev_rd_en = c3_p1_rd_en;
      prev_cmd_en = c3_p1_cmd_en;
    end
  end

  task automatic check_leds();
    int frames;
    frames = bursts / BURST;
    check("led", 64'(led), 64'({err_model, 5'(frames), 1'(frames), 1'b1}));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_en"}, 64'(c3_p1_cmd_en), 64'd0);
    check({tag, "_cmd_instr"}, 64'(c3_p1_cmd_instr), 64'd0);
    check({tag, "_cmd_bl"}, 64'(c3_p1_cmd_bl), 64'd0);
    check({tag, "_cmd_addr"}, 64'(c3_p1_cmd_byte_addr), 64'd0);
    check({tag, "_rd_en"}, 64'(c3_p1_rd_en), 64'd0);
    check({tag, "_fifo_we"}, 64'(fifo_write_enable), 64'd0);
    check({tag, "_fifo_data"}, 64'(fifo_data_in), 64'd0);
    check({tag, "_led"}, 64'(led), 64'd0);
  endtask

  // Allows exactly one burst: expected command and pixels are queued from the frame layout.
  task automatic run_burst(input int count_val, input int cmd_limit, input bit inject_err,
                           input int abort_after);
    logic [29:0] a;
    logic [31:0] w;
    int start, n;
    bit seen;
    a = 30'(256 * (bursts % BURST));
    exp_cmd_q.push_back(a);
    for (int i = 0; i < 64; i++) begin
      w = mem_word(a + 30'(4 * i));
      exp_pix_q.push_back(w[23:0]);
    end
    start = pix_rx;
    fifo_wr_data_count = 11'(count_val);
    n = 0;
    while (!c3_p1_cmd_en && n < 300) begin
      tick();
      n++;
    end
    if (!c3_p1_cmd_en) note_fail("cmd_timeout");
    else if (cmd_limit > 0) check("cmd_latency_ok", 64'(n <= cmd_limit), 64'd1);
    fifo_wr_data_count = 11'd1985;
    if (inject_err) begin
      repeat (8) tick();
      c3_p1_rd_error = 1'b1;
      tick();
      c3_p1_rd_error = 1'b0;
      err_model = 1'b1;
    end
    if (abort_after > 0) begin
      n = 0;
      while (pix_rx < start + abort_after && n < 2000) begin tick(); n++; end
      if (pix_rx < start + abort_after) note_fail("abort_wait_timeout");
      rst = 1'b1;
      tick();
      check_all_zero("midburst_reset");
      exp_pix_q.delete();
      exp_cmd_q.delete();
      mig_q.delete();
      bursts = 0;
      err_model = 1'b0;
      rst = 1'b0;
      seen = 1'b0;
      repeat (30) begin
        tick();
        if (c3_p1_rd_en || c3_p1_cmd_en || fifo_write_enable) seen = 1'b1;
      end
      check("quiet_after_reset", 64'(seen), 64'd0);
      return;
    end
    n = 0;
    while (pix_rx < start + 64 && n < 3000) begin tick(); n++; end
    if (pix_rx < start + 64) note_fail("burst_timeout");
    bursts++;
    repeat (4) tick();
    check("burst_pixel_count", 64'(pix_rx - start), 64'd64);
    check_leds();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    bit seen;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Uncalibrated with an empty FIFO: nothing may be requested; faults here are ignored.
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 40) c3_p1_rd_overflow = 1'b1;
      if (i == 41) c3_p1_rd_overflow = 1'b0;
      tick();
      if (c3_p1_cmd_en) seen = 1'b1;
    end
    check("no_cmd_before_calib", 64'(seen), 64'd0);
    check("led_before_calib", 64'(led), 64'd0);

    c3_calib_done = 1'b1;
    run_burst(0, 3, 1'b0, 0);

    // Count just over the threshold must hold off the next request.
    seen = 1'b0;
    repeat (60) begin
      tick();
      if (c3_p1_cmd_en) seen = 1'b1;
    end
    check("hold_at_1985", 64'(seen), 64'd0);
    run_burst(1984, 5, 1'b0, 0);

    rand_en = 1'b1;
    for (int b = 0; b < 8; b++) run_burst($urandom_range(0, 1984), 0, b == 3, 0);
    run_burst(100, 0, 1'b0, 20);
    for (int b = 0; b < 5; b++) run_burst($urandom_range(0, 1984), 0, 1'b0, 0);

    n = 0;
    while ((exp_pix_q.size() != 0 || exp_cmd_q.size() != 0) && n < 50) begin tick(); n++; end
    check("scoreboard_drained", 64'(exp_pix_q.size() + exp_cmd_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
